// File: rtl/multi_sprite_print_module.sv
`default_nettype none
// ============================================================================
// Module      : multi_sprite_print_module
// Description : Per-line scan of NUM_SLOTS sprite descriptors into a short
//               visible list. A two-stage pixel pipeline then emits the
//               sprite-ROM address of the lowest-slot sprite covering the
//               pixel. Optional feature macro: SPRITE_MIRROR_EN (horizontal
//               mirroring through descriptor bit 10).
// Revision    : 1.0 - initial release
// ============================================================================
module multi_sprite_print_module #(
    parameter int NUM_SLOTS    = 8,
    parameter int SLOT_BITS    = 3,
    parameter int SIZE_X       = 10,
    parameter int SIZE_Y       = 10,
    parameter int SPRITE_W     = 20,
    parameter int SPRITE_H     = 20,
    parameter int SIZE_ADDRESS = 14,
    parameter int MAX_PER_LINE = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [SLOT_BITS-1:0]     wr_slot,
    input  logic [31:0]              wr_data,
    input  logic                     line_start,
    input  logic [SIZE_Y-1:0]        line_y,
    input  logic                     pixel_en,
    input  logic                     active_area,
    input  logic [SIZE_X-1:0]        pixel_x,
    output logic [SIZE_ADDRESS-1:0]  memory_address,
    output logic [SIZE_X+SIZE_Y-1:0] check_value,
    output logic [SLOT_BITS-1:0]     sprite_slot,
    output logic                     printting,
    output logic                     scan_busy,
    output logic                     overflow
);

    localparam int c_CNT_W = $clog2(MAX_PER_LINE + 1);
    localparam int c_IDX_W = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;

    typedef enum logic [1:0] {
        c_ST_IDLE  = 2'd0,
        c_ST_READY = 2'd1,
        c_ST_SCAN  = 2'd2
    } state_t;

    typedef struct packed {
        logic              active;
        logic [SIZE_X-1:0] pos_x;
        logic [SIZE_Y-1:0] pos_y;
`ifdef SPRITE_MIRROR_EN
        logic              mirror;
`endif
        logic [8:0]        offset;
    } slot_t;

    typedef struct packed {
        logic [SLOT_BITS-1:0] slot;
        logic [SIZE_X-1:0]    pos_x;
        logic [SIZE_Y-1:0]    pos_y;
        logic [SIZE_Y-1:0]    row;
`ifdef SPRITE_MIRROR_EN
        logic                 mirror;
`endif
        logic [8:0]           offset;
    } entry_t;

    slot_t                     r_slots_q [NUM_SLOTS];
    slot_t                     w_slots_d [NUM_SLOTS];
    entry_t                    r_list_q  [MAX_PER_LINE];
    entry_t                    w_list_d  [MAX_PER_LINE];
    state_t                    r_state_q, w_state_d;
    logic [SLOT_BITS-1:0]      r_scan_idx_q, w_scan_idx_d;
    logic [c_CNT_W-1:0]        r_count_q, w_count_d;
    logic                      r_overflow_q, w_overflow_d;
    logic [SIZE_Y-1:0]         r_line_y_q, w_line_y_d;
    logic                      r_s1_fire_q, w_s1_fire_d;
    logic [MAX_PER_LINE-1:0]   r_hit_q, w_hit_d;
    logic [SIZE_X-1:0]         r_col_q [MAX_PER_LINE];
    logic [SIZE_X-1:0]         w_col_d [MAX_PER_LINE];
    logic [SIZE_ADDRESS-1:0]   r_addr_q, w_addr_d;
    logic [SIZE_X+SIZE_Y-1:0]  r_check_q, w_check_d;
    logic [SLOT_BITS-1:0]      r_slot_q, w_slot_d;
    logic                      r_print_q, w_print_d;

    slot_t                     w_cur;
    entry_t                    w_new;
    entry_t                    w_ent;
    logic                      w_scan_hit;
    logic                      w_s1_ok;
    logic [SIZE_X-1:0]         w_dx;
    logic [SIZE_X-1:0]         w_col;
    logic                      w_found;
    logic [c_IDX_W-1:0]        w_sel;
    logic [31:0]               w_addr_full;
    logic                      w_unused_bits;

`ifdef SPRITE_MIRROR_EN
    assign w_unused_bits = wr_data[9];
`else
    assign w_unused_bits = ^wr_data[10:9];
`endif

    always_comb begin
        w_slots_d = r_slots_q;
        if (wr_en) begin
            w_slots_d[wr_slot].active = wr_data[31];
            w_slots_d[wr_slot].pos_x  = wr_data[30:21];
            w_slots_d[wr_slot].pos_y  = wr_data[20:11];
`ifdef SPRITE_MIRROR_EN
            w_slots_d[wr_slot].mirror = wr_data[10];
`endif
            w_slots_d[wr_slot].offset = wr_data[8:0];
        end
    end

    // Slot under scan is read from the registered array, so a write landing
    // on an earlier edge is visible to this line.
    assign w_cur      = r_slots_q[r_scan_idx_q];
    assign w_scan_hit = w_cur.active
                     && ({1'b0, r_line_y_q} >= {1'b0, w_cur.pos_y})
                     && ({1'b0, r_line_y_q} < ({1'b0, w_cur.pos_y} + (SIZE_Y+1)'(SPRITE_H)));

    always_comb begin
        w_new        = '0;
        w_new.slot   = r_scan_idx_q;
        w_new.pos_x  = w_cur.pos_x;
        w_new.pos_y  = w_cur.pos_y;
        w_new.row    = r_line_y_q - w_cur.pos_y;
        w_new.offset = w_cur.offset;
`ifdef SPRITE_MIRROR_EN
        w_new.mirror = w_cur.mirror;
`endif
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_scan_idx_d = r_scan_idx_q;
        w_count_d    = r_count_q;
        w_overflow_d = r_overflow_q;
        w_line_y_d   = r_line_y_q;
        w_list_d     = r_list_q;
        if (line_start) begin
            w_state_d    = c_ST_SCAN;
            w_scan_idx_d = '0;
            w_count_d    = '0;
            w_overflow_d = 1'b0;
            w_line_y_d   = line_y;
        end else if (r_state_q == c_ST_SCAN) begin
            if (w_scan_hit) begin
                if (r_count_q < c_CNT_W'(MAX_PER_LINE)) begin
                    w_list_d[r_count_q[c_IDX_W-1:0]] = w_new;
                    w_count_d = r_count_q + 1'b1;
                end else begin
                    w_overflow_d = 1'b1;
                end
            end
            if (r_scan_idx_q == SLOT_BITS'(NUM_SLOTS - 1)) begin
                w_state_d = c_ST_READY;
            end else begin
                w_scan_idx_d = r_scan_idx_q + 1'b1;
            end
        end
    end

    // A pixel coinciding with a new scan is blanked, as the list is being rebuilt.
    assign w_s1_ok = active_area && (r_state_q == c_ST_READY) && !line_start;

    always_comb begin
        w_s1_fire_d = pixel_en;
        w_hit_d     = r_hit_q;
        w_col_d     = r_col_q;
        w_dx        = '0;
        if (pixel_en) begin
            for (int i = 0; i < MAX_PER_LINE; i++) begin
                w_dx       = pixel_x - r_list_q[i].pos_x;
                w_hit_d[i] = w_s1_ok && (c_CNT_W'(i) < r_count_q)
                          && ({1'b0, pixel_x} >= {1'b0, r_list_q[i].pos_x})
                          && ({1'b0, pixel_x} < ({1'b0, r_list_q[i].pos_x} + (SIZE_X+1)'(SPRITE_W)));
`ifdef SPRITE_MIRROR_EN
                w_col_d[i] = r_list_q[i].mirror ? (SIZE_X'(SPRITE_W - 1) - w_dx) : w_dx;
`else
                w_col_d[i] = w_dx;
`endif
            end
        end
    end

    // List order follows slot order, so the lowest hit index is the lowest slot.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = MAX_PER_LINE - 1; i >= 0; i--) begin
            if (r_hit_q[i]) begin
                w_found = 1'b1;
                w_sel   = c_IDX_W'(i);
            end
        end
        w_ent       = r_list_q[w_sel];
        w_col       = r_col_q[w_sel];
        w_addr_full = 32'(w_ent.offset) * 32'(SPRITE_W * SPRITE_H)
                    + 32'(w_ent.row) * 32'(SPRITE_W) + 32'(w_col);
        w_addr_d    = r_addr_q;
        w_check_d   = r_check_q;
        w_slot_d    = r_slot_q;
        w_print_d   = r_print_q;
        if (r_s1_fire_q) begin
            w_print_d = w_found;
            w_addr_d  = w_found ? w_addr_full[SIZE_ADDRESS-1:0] : '0;
            w_check_d = w_found ? {w_ent.pos_x, w_ent.pos_y} : '0;
            w_slot_d  = w_found ? w_ent.slot : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_slots_q[i] <= '0;
            end
            for (int i = 0; i < MAX_PER_LINE; i++) begin
                r_list_q[i] <= '0;
                r_col_q[i]  <= '0;
            end
            r_state_q    <= c_ST_IDLE;
            r_scan_idx_q <= '0;
            r_count_q    <= '0;
            r_overflow_q <= 1'b0;
            r_line_y_q   <= '0;
            r_s1_fire_q  <= 1'b0;
            r_hit_q      <= '0;
            r_addr_q     <= '0;
            r_check_q    <= '0;
            r_slot_q     <= '0;
            r_print_q    <= 1'b0;
        end else begin
            r_slots_q    <= w_slots_d;
            r_list_q     <= w_list_d;
            r_col_q      <= w_col_d;
            r_state_q    <= w_state_d;
            r_scan_idx_q <= w_scan_idx_d;
            r_count_q    <= w_count_d;
            r_overflow_q <= w_overflow_d;
            r_line_y_q   <= w_line_y_d;
            r_s1_fire_q  <= w_s1_fire_d;
            r_hit_q      <= w_hit_d;
            r_addr_q     <= w_addr_d;
            r_check_q    <= w_check_d;
            r_slot_q     <= w_slot_d;
            r_print_q    <= w_print_d;
        end
    end

    assign memory_address = r_addr_q;
    assign check_value    = r_check_q;
    assign sprite_slot    = r_slot_q;
    assign printting      = r_print_q;
    assign scan_busy      = (r_state_q == c_ST_SCAN);
    assign overflow       = r_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_sprite_print_module.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_sprite_print_module
// Description : Scoreboard bench for multi_sprite_print_module; pixel
//               expectations are queued by the stimulus and checked by a
//               monitor two clocks after each pixel strobe. Honours
//               SPRITE_MIRROR_EN for the mirrored-address expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_sprite_print_module;

    typedef struct {
        logic        p;
        logic [13:0] a;
        logic [19:0] c;
        logic [2:0]  s;
    } exp_t;

`ifdef SPRITE_MIRROR_EN
    localparam logic [13:0] c_MIRROR_ADDR = 14'd914;
`else
    localparam logic [13:0] c_MIRROR_ADDR = 14'd905;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_slot = '0;
    logic [31:0] wr_data = '0;
    logic        line_start = 1'b0;
    logic [9:0]  line_y = '0;
    logic        pixel_en = 1'b0;
    logic        active_area = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [13:0] memory_address;
    logic [19:0] check_value;
    logic [2:0]  sprite_slot;
    logic        printting;
    logic        scan_busy;
    logic        overflow;

    int    total = 0;
    int    bad   = 0;
    exp_t  sb_q[$];
    string nm_q[$];

    multi_sprite_print_module dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .wr_slot        (wr_slot),
        .wr_data        (wr_data),
        .line_start     (line_start),
        .line_y         (line_y),
        .pixel_en       (pixel_en),
        .active_area    (active_area),
        .pixel_x        (pixel_x),
        .memory_address (memory_address),
        .check_value    (check_value),
        .sprite_slot    (sprite_slot),
        .printting      (printting),
        .scan_busy      (scan_busy),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: a strobe sampled at edge N has its result visible after edge N+1.
    initial begin
        logic  p1, p2;
        exp_t  e;
        string nm;
        p1 = 1'b0;
        p2 = 1'b0;
        forever begin
            @(posedge clk);
            p2 = p1;
            p1 = pixel_en & ~reset;
            if (p2) begin
                #1;
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got output with no expectation queued");
                end else begin
                    e  = sb_q.pop_front();
                    nm = nm_q.pop_front();
                    chk(nm, {26'd0, printting, memory_address, check_value, sprite_slot},
                            {26'd0, e.p, e.a, e.c, e.s});
                end
            end
        end
    end

    task automatic push(input string nm, input logic ep, input logic [13:0] ea,
                        input logic [9:0] ex, input logic [9:0] ey, input logic [2:0] es);
        exp_t e;
        e.p = ep;
        e.a = ea;
        e.c = {ex, ey};
        e.s = es;
        sb_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic wr(input logic [2:0] slot, input logic act, input logic [9:0] x,
                      input logic [9:0] y, input logic m, input logic [8:0] off);
        wr_slot = slot;
        wr_data = {act, x, y, m, 1'b0, off};
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_scan(input string nm, input int exp_len);
        int n;
        n = 0;
        while (scan_busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk(nm, 64'(n), 64'(exp_len));
    endtask

    task automatic start_line(input logic [9:0] y);
        line_y     = y;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        wait_scan("scan_len", 8);
    endtask

    task automatic pix(input string nm, input logic [9:0] x, input logic aa, input logic ep,
                       input logic [13:0] ea, input logic [9:0] ex, input logic [9:0] ey,
                       input logic [2:0] es);
        push(nm, ep, ea, ex, ey, es);
        pixel_x     = x;
        active_area = aa;
        pixel_en    = 1'b1;
        @(negedge clk);
        pixel_en    = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_print"}, 64'(printting), 64'd0);
        chk({nm, "_addr"},  64'(memory_address), 64'd0);
        chk({nm, "_check"}, 64'(check_value), 64'd0);
        chk({nm, "_slot"},  64'(sprite_slot), 64'd0);
        chk({nm, "_busy"},  64'(scan_busy), 64'd0);
        chk({nm, "_ovf"},   64'(overflow), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single sprite, body and edges
        wr(3'd0, 1'b1, 10'd100, 10'd50, 1'b0, 9'd2);
        start_line(10'd55);
        pix("basic_105", 10'd105, 1'b1, 1'b1, 14'd905, 10'd100, 10'd50, 3'd0);
        pix("right_119", 10'd119, 1'b1, 1'b1, 14'd919, 10'd100, 10'd50, 3'd0);
        pix("past_120",  10'd120, 1'b1, 1'b0, 14'd0, 10'd0, 10'd0, 3'd0);
        pix("before_99", 10'd99,  1'b1, 1'b0, 14'd0, 10'd0, 10'd0, 3'd0);
        pix("inactive_area", 10'd105, 1'b0, 1'b0, 14'd0, 10'd0, 10'd0, 3'd0);

        // Priority, snapshot, then the other slot alone
        wr(3'd3, 1'b1, 10'd110, 10'd50, 1'b0, 9'd1);
        start_line(10'd55);
        pix("prio_slot0", 10'd112, 1'b1, 1'b1, 14'd912, 10'd100, 10'd50, 3'd0);
        wr(3'd0, 1'b0, 10'd0, 10'd0, 1'b0, 9'd0);
        pix("snapshot", 10'd105, 1'b1, 1'b1, 14'd905, 10'd100, 10'd50, 3'd0);
        start_line(10'd55);
        pix("slot3_only", 10'd112, 1'b1, 1'b1, 14'd502, 10'd110, 10'd50, 3'd3);

        // Pixel during scan, then restart mid-scan
        push("pix_busy", 1'b0, 14'd0, 10'd0, 10'd0, 3'd0);
        line_y     = 10'd55;
        line_start = 1'b1;
        @(negedge clk);
        line_start  = 1'b0;
        pixel_x     = 10'd112;
        active_area = 1'b1;
        pixel_en    = 1'b1;
        @(negedge clk);
        pixel_en   = 1'b0;
        @(negedge clk);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        wait_scan("restart_len", 8);
        pix("after_restart", 10'd112, 1'b1, 1'b1, 14'd502, 10'd110, 10'd50, 3'd3);

        // line_start and pixel_en together
        push("same_clk", 1'b0, 14'd0, 10'd0, 10'd0, 3'd0);
        pixel_x    = 10'd112;
        pixel_en   = 1'b1;
        line_start = 1'b1;
        @(negedge clk);
        pixel_en   = 1'b0;
        line_start = 1'b0;
        wait_scan("same_clk_len", 8);

        // Mirror bit
        wr(3'd0, 1'b1, 10'd100, 10'd50, 1'b1, 9'd2);
        start_line(10'd55);
        pix("mirror", 10'd105, 1'b1, 1'b1, c_MIRROR_ADDR, 10'd100, 10'd50, 3'd0);

        // Overflow: five sprites on one line
        for (int k = 0; k < 5; k++) begin
            wr(3'(k), 1'b1, 10'(100 + 40 * k), 10'd50, 1'b0, 9'd0);
        end
        start_line(10'd50);
        chk("overflow_set", 64'(overflow), 64'd1);
        pix("slot4_dropped", 10'd265, 1'b1, 1'b0, 14'd0, 10'd0, 10'd0, 3'd0);
        pix("slot3_kept", 10'd225, 1'b1, 1'b1, 14'd5, 10'd220, 10'd50, 3'd3);
        pix("slot0_kept", 10'd105, 1'b1, 1'b1, 14'd5, 10'd100, 10'd50, 3'd0);

        // New line clears overflow; write to slot6 during the scan is seen
        line_y     = 10'd200;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        wr(3'd6, 1'b1, 10'd400, 10'd195, 1'b0, 9'd3);
        wait_scan("scan_wr_len", 7);
        chk("overflow_clr", 64'(overflow), 64'd0);
        pix("wr_in_scan", 10'd410, 1'b1, 1'b1, 14'd1310, 10'd400, 10'd195, 3'd6);

        // Reset in the middle of a scan
        line_y     = 10'd200;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_reset");
        reset = 1'b0;
        @(negedge clk);
        pix("idle_after_rst", 10'd410, 1'b1, 1'b0, 14'd0, 10'd0, 10'd0, 3'd0);

        repeat (5) @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
